// File: rtl/quad_pkg.sv
// Shared constants for the quadrature decoder: count modes and {A,B} Gray phases.
package quad_pkg;
  localparam logic [1:0] MODE_X1 = 2'd0;
  localparam logic [1:0] MODE_X2 = 2'd1;
  localparam logic [1:0] MODE_X4 = 2'd2;

  // {A,B} states in forward order; A leads B when moving forward.
  localparam logic [1:0] GRAY_S0 = 2'b00;
  localparam logic [1:0] GRAY_S1 = 2'b10;
  localparam logic [1:0] GRAY_S2 = 2'b11;
  localparam logic [1:0] GRAY_S3 = 2'b01;

  // Phase 0..3 of an {A,B} state, so that a forward step is phase+1 mod 4.
  function automatic logic [1:0] gray_phase(input logic [1:0] ab);
    case (ab)
      GRAY_S0: gray_phase = 2'd0;
      GRAY_S1: gray_phase = 2'd1;
      GRAY_S2: gray_phase = 2'd2;
      default: gray_phase = 2'd3;
    endcase
  endfunction
endpackage

// File: rtl/glitch_filter.sv
// 2-FF synchroniser followed by a stability filter; the first synced sample
// after reset is loaded straight into the output so reset-time levels never count.
module glitch_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);
  localparam logic [7:0] CNT_MAX = 8'(FILTER_LEN - 1);

  logic       s1, s2;
  logic [1:0] stg;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      stg <= 2'd0;
      cnt <= 8'd0;
      out <= 1'b0;
    end else begin
      s1 <= in;
      s2 <= s1;
      if (stg != 2'd3) stg <= stg + 2'd1;
      // stg==2: s2 holds the first valid synced sample
      if (stg == 2'd2) begin
        out <= s2;
        cnt <= 8'd0;
      end else if (stg == 2'd3) begin
        if (s2 == out) begin
          cnt <= 8'd0;
        end else if (cnt == CNT_MAX) begin
          out <= s2;
          cnt <= 8'd0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end
endmodule

// File: rtl/quad_decoder_counter.sv
// Quadrature encoder front end: filtered A/B/I decode into step pulses, direction,
// a modulo position counter with index clear / preload, and illegal-transition counting.
module quad_decoder_counter
  import quad_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FILTER_LEN = 4,
  parameter int ERR_W      = 8,
  parameter bit REVERSE    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inA,
  input  logic             inB,
  input  logic             inI,
  input  logic [1:0]       mode,
  input  logic             idx_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             plus1,
  output logic             minus1,
  output logic             dir,
  output logic [WIDTH-1:0] pos,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);
  logic       fa, fb, fi;
  logic [1:0] cur, prev_ab;
  logic       prev_i;
  logic [3:0] arm_pipe;
  logic       armed;
  logic [1:0] delta;
  logic       a_chg, fwd, rev, step_f, step_r, err_now, idx_hit;

  glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (.clk(clk), .rst(rst), .in(inA), .out(fa));
  glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (.clk(clk), .rst(rst), .in(inB), .out(fb));
  glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_i (.clk(clk), .rst(rst), .in(inI), .out(fi));

  // Filters load at edge 3, prev follows at edge 4; decoding starts the edge after.
  assign armed = arm_pipe[3];
  assign cur   = {fa, fb};
  assign delta = gray_phase(cur) - gray_phase(prev_ab);
  assign a_chg = fa ^ prev_ab[1];

  always_comb begin
    fwd = 1'b0;
    rev = 1'b0;
    case (mode)
      MODE_X1: begin
        fwd = (prev_ab == GRAY_S0) && (cur == GRAY_S1);
        rev = (prev_ab == GRAY_S1) && (cur == GRAY_S0);
      end
      MODE_X2: begin
        fwd = (delta == 2'd1) && a_chg;
        rev = (delta == 2'd3) && a_chg;
      end
      default: begin
        fwd = (delta == 2'd1);
        rev = (delta == 2'd3);
      end
    endcase
  end

  assign step_f  = armed && (REVERSE ? rev : fwd);
  assign step_r  = armed && (REVERSE ? fwd : rev);
  assign err_now = armed && (delta == 2'd2);
  assign idx_hit = armed && idx_en && fi && !prev_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      arm_pipe <= 4'd0;
      prev_ab  <= 2'b00;
      prev_i   <= 1'b0;
      plus1    <= 1'b0;
      minus1   <= 1'b0;
      dir      <= 1'b1;
      pos      <= '0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      arm_pipe <= {arm_pipe[2:0], 1'b1};
      prev_ab  <= cur;
      prev_i   <= fi;
      plus1    <= step_f;
      minus1   <= step_r;
      err      <= err_now;
      if (step_f)      dir <= 1'b1;
      else if (step_r) dir <= 1'b0;
      if (err_now && (err_cnt != {ERR_W{1'b1}})) err_cnt <= err_cnt + ERR_W'(1);
      // load beats index beats a step; the step still produces its pulse and dir
      if (load)         pos <= load_val;
      else if (idx_hit) pos <= '0;
      else if (step_f)  pos <= pos + WIDTH'(1);
      else if (step_r)  pos <= pos - WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_quad_decoder_counter.sv
// Bench for quad_decoder_counter: directed corner sequences, a transition table,
// and a random walk against a phase-arithmetic position model.
module tb_quad_decoder_counter;
  localparam int WIDTH = 16;
  localparam int FL    = 4;
  localparam int ERR_W = 8;
  localparam int HOLD  = 12;

  logic clk = 1'b0, rst = 1'b1;
  logic inA = 1'b0, inB = 1'b0, inI = 1'b0;
  logic [1:0] mode = 2'd2;
  logic idx_en = 1'b0, load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic plus1, minus1, dir, err;
  logic [WIDTH-1:0] pos;
  logic [ERR_W-1:0] err_cnt;

  int n_chk = 0, n_fail = 0;
  int tot_p = 0, tot_m = 0, tot_e = 0;
  int p0, m0, e0;

  typedef struct {
    logic [1:0] md;
    logic [1:0] from;
    logic [1:0] to;
    int ep, em, ee;
  } vec_t;
  vec_t vecs [22];
  logic [1:0] seq [4];

  quad_decoder_counter #(.WIDTH(WIDTH), .FILTER_LEN(FL), .ERR_W(ERR_W), .REVERSE(1'b0)) dut (
    .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inI(inI), .mode(mode),
    .idx_en(idx_en), .load(load), .load_val(load_val),
    .plus1(plus1), .minus1(minus1), .dir(dir), .pos(pos), .err(err), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (plus1)  tot_p++;
    if (minus1) tot_m++;
    if (err)    tot_e++;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ab(input logic [1:0] s, input int n);
    inA = s[1];
    inB = s[0];
    tick(n);
  endtask

  task automatic snap();
    p0 = tot_p;
    m0 = tot_m;
    e0 = tot_e;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(10);
  endtask

  function automatic int phase_of(input logic [1:0] s);
    phase_of = 0;
    for (int i = 0; i < 4; i++) if (seq[i] == s) phase_of = i;
  endfunction

  initial begin
    int lat;
    logic [WIDTH-1:0] pb, mpos;
    int merr, mp, mm;
    logic [1:0] cur, nxt;

    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
    vecs[0]  = '{2'd2, 2'b00, 2'b10, 1, 0, 0};
    vecs[1]  = '{2'd2, 2'b10, 2'b11, 1, 0, 0};
    vecs[2]  = '{2'd2, 2'b11, 2'b01, 1, 0, 0};
    vecs[3]  = '{2'd2, 2'b01, 2'b00, 1, 0, 0};
    vecs[4]  = '{2'd2, 2'b00, 2'b01, 0, 1, 0};
    vecs[5]  = '{2'd2, 2'b01, 2'b11, 0, 1, 0};
    vecs[6]  = '{2'd2, 2'b11, 2'b10, 0, 1, 0};
    vecs[7]  = '{2'd2, 2'b10, 2'b00, 0, 1, 0};
    vecs[8]  = '{2'd2, 2'b00, 2'b11, 0, 0, 1};
    vecs[9]  = '{2'd2, 2'b10, 2'b01, 0, 0, 1};
    vecs[10] = '{2'd1, 2'b00, 2'b10, 1, 0, 0};
    vecs[11] = '{2'd1, 2'b10, 2'b11, 0, 0, 0};
    vecs[12] = '{2'd1, 2'b11, 2'b01, 1, 0, 0};
    vecs[13] = '{2'd1, 2'b01, 2'b11, 0, 1, 0};
    vecs[14] = '{2'd1, 2'b10, 2'b00, 0, 1, 0};
    vecs[15] = '{2'd1, 2'b00, 2'b01, 0, 0, 0};
    vecs[16] = '{2'd0, 2'b00, 2'b10, 1, 0, 0};
    vecs[17] = '{2'd0, 2'b11, 2'b01, 0, 0, 0};
    vecs[18] = '{2'd0, 2'b10, 2'b00, 0, 1, 0};
    vecs[19] = '{2'd0, 2'b01, 2'b11, 0, 0, 0};
    vecs[20] = '{2'd0, 2'b01, 2'b10, 0, 0, 1};
    vecs[21] = '{2'd3, 2'b10, 2'b11, 1, 0, 0};

    // reset values
    tick(3);
    chk("rst_plus1", plus1, 0);
    chk("rst_minus1", minus1, 0);
    chk("rst_dir", dir, 1);
    chk("rst_pos", pos, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    tick(10);

    // x4 forward: 10 full cycles, first-pulse latency
    mode = 2'd2;
    snap();
    inA = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (plus1 && lat == 0) lat = n;
    end
    tick(20);
    chk("fwd_latency", lat, FL + 3);
    for (int k = 1; k < 40; k++) set_ab(seq[(k + 1) % 4], 40);
    chk("fwd_plus_cnt", tot_p - p0, 40);
    chk("fwd_minus_cnt", tot_m - m0, 0);
    chk("fwd_pos", pos, 40);
    chk("fwd_dir", dir, 1);

    // x1 reverse from 0
    load_val = '0;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    mode = 2'd0;
    snap();
    for (int k = 0; k < 12; k++) set_ab(seq[(3 - (k % 4)) % 4], HOLD);
    chk("rev_minus_cnt", tot_m - m0, 3);
    chk("rev_plus_cnt", tot_p - p0, 0);
    chk("rev_pos", pos, 16'hFFFD);
    chk("rev_dir", dir, 0);

    // glitches on A (x4, state 00)
    mode = 2'd2;
    snap();
    inA = 1'b1; tick(FL - 1); inA = 1'b0; tick(20);
    chk("glitch3_plus", tot_p - p0, 0);
    chk("glitch3_minus", tot_m - m0, 0);
    chk("glitch3_pos", pos, 16'hFFFD);
    inA = 1'b1; tick(FL); inA = 1'b0; tick(20);
    chk("glitch4_plus", tot_p - p0, 1);
    chk("glitch4_minus", tot_m - m0, 1);
    chk("glitch4_pos", pos, 16'hFFFD);

    // transition table
    for (int v = 0; v < 22; v++) begin
      mode = vecs[v].md;
      set_ab(vecs[v].from, HOLD);
      snap();
      pb = pos;
      set_ab(vecs[v].to, HOLD);
      chk($sformatf("vec%0d_plus", v), tot_p - p0, vecs[v].ep);
      chk($sformatf("vec%0d_minus", v), tot_m - m0, vecs[v].em);
      chk($sformatf("vec%0d_err", v), tot_e - e0, vecs[v].ee);
      chk($sformatf("vec%0d_pos", v), pos, WIDTH'(pb + WIDTH'(vecs[v].ep) - WIDTH'(vecs[v].em)));
    end

    // illegal jumps and error saturation
    set_ab(2'b00, HOLD);
    do_reset();
    mode = 2'd2;
    snap();
    set_ab(2'b11, HOLD);
    chk("err1_pulse", tot_e - e0, 1);
    chk("err1_cnt", err_cnt, 1);
    chk("err1_pos", pos, 0);
    for (int k = 1; k < 300; k++) set_ab((k % 2) ? 2'b00 : 2'b11, HOLD);
    chk("err300_pulses", tot_e - e0, 300);
    chk("err300_sat", err_cnt, 255);
    chk("err300_pos", pos, 0);
    chk("err300_steps", (tot_p - p0) + (tot_m - m0), 0);

    // index with coincident step, then load coincident with index
    load_val = 16'd100;
    load = 1'b1; tick(1); load = 1'b0;
    chk("load100_pos", pos, 100);
    idx_en = 1'b1;
    snap();
    inI = 1'b1;
    set_ab(2'b10, HOLD);
    chk("idx_step_pos", pos, 0);
    chk("idx_step_plus", tot_p - p0, 1);
    inI = 1'b0; tick(HOLD);
    load_val = 16'h1234;
    inI = 1'b1;
    tick(FL + 2);
    load = 1'b1; tick(1); load = 1'b0;
    tick(HOLD);
    chk("load_idx_pos", pos, 16'h1234);
    inI = 1'b0; tick(HOLD);
    idx_en = 1'b0;
    inI = 1'b1; tick(HOLD);
    chk("idx_dis_pos", pos, 16'h1234);
    inI = 1'b0;

    // lines held at 11 through reset release
    inA = 1'b1; inB = 1'b1;
    rst = 1'b1; tick(3); rst = 1'b0;
    snap();
    tick(20);
    chk("hold11_err", tot_e - e0, 0);
    chk("hold11_steps", (tot_p - p0) + (tot_m - m0), 0);
    chk("hold11_err_cnt", err_cnt, 0);
    chk("hold11_pos", pos, 0);
    set_ab(2'b01, HOLD);
    chk("hold11_step_plus", tot_p - p0, 1);
    chk("hold11_step_minus", tot_m - m0, 0);
    chk("hold11_step_pos", pos, 1);

    // random walk against phase model (re-armed from state 01)
    do_reset();
    cur = 2'b01;
    mpos = '0; merr = 0; mp = 0; mm = 0;
    snap();
    for (int k = 0; k < 200; k++) begin
      int pi, ni, d;
      logic f, r;
      mode = 2'($urandom_range(0, 3));
      nxt = seq[$urandom_range(0, 3)];
      pi = phase_of(cur);
      ni = phase_of(nxt);
      d = (ni - pi + 4) % 4;
      f = 1'b0; r = 1'b0;
      if (mode == 2'd0) begin
        f = (pi == 0 && ni == 1);
        r = (pi == 1 && ni == 0);
      end else if (mode == 2'd1) begin
        f = (d == 1) && (pi == 0 || pi == 2);
        r = (d == 3) && (pi == 1 || pi == 3);
      end else begin
        f = (d == 1);
        r = (d == 3);
      end
      if (d == 2 && merr < 255) merr++;
      if (f) begin mpos = mpos + 1'b1; mp++; end
      if (r) begin mpos = mpos - 1'b1; mm++; end
      set_ab(nxt, HOLD);
      cur = nxt;
      chk($sformatf("rnd%0d_pos", k), pos, mpos);
      chk($sformatf("rnd%0d_err_cnt", k), err_cnt, merr);
    end
    chk("rnd_plus_total", tot_p - p0, mp);
    chk("rnd_minus_total", tot_m - m0, mm);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
